// File: rtl/cva6_spi_pkg.sv
// Shared types and helpers for the CVA6 SPI master transmit path.
// Lane-mode decode, lane counts and the FSM state encoding.
package cva6_spi_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    DUAL   = 2'b01,
    QUAD   = 2'b10
  } spi_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    TRANSMIT = 1'b1
  } tx_state_e;

  localparam int unsigned TRGT_RST = 8;

  // Encoding 11 falls back to single-lane operation.
  function automatic spi_mode_e mode_dec(input logic [1:0] m);
    case (m)
      2'b01:   return DUAL;
      2'b10:   return QUAD;
      default: return SINGLE;
    endcase
  endfunction

  function automatic logic [1:0] lane_log2(input spi_mode_e m);
    case (m)
      QUAD:    return 2'd2;
      DUAL:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input spi_mode_e m);
    case (m)
      QUAD:    return 4'b1111;
      DUAL:    return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

endpackage

// File: rtl/cva6_spi_tx_shreg.sv
// Transmit shift register: load, shift by lane count in either
// bit order, and map the outgoing bits onto the SDO lanes.
module cva6_spi_tx_shreg
  import cva6_spi_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  input  spi_mode_e         mode_i,
  input  logic              lsb_i,
  output logic [3:0]        sdo_o
);

  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] sr_d;
  logic [DATA_W-1:0] shl;
  logic [DATA_W-1:0] shr;

  always_comb begin
    shl = sr_q << 1;
    shr = sr_q >> 1;
    sdo_o = {3'b000, lsb_i ? sr_q[0] : sr_q[DATA_W-1]};
    case (mode_i)
      QUAD: begin
        shl = sr_q << 4;
        shr = sr_q >> 4;
        sdo_o = lsb_i ? sr_q[3:0] : sr_q[DATA_W-1 -: 4];
      end
      DUAL: begin
        shl = sr_q << 2;
        shr = sr_q >> 2;
        sdo_o = {2'b00, lsb_i ? sr_q[1:0] : sr_q[DATA_W-1 -: 2]};
      end
      default: ;
    endcase
  end

  // Load beats clear: a back-to-back word replaces the tail bits.
  always_comb begin
    sr_d = sr_q;
    if (load_i)       sr_d = data_i;
    else if (clr_i)   sr_d = '0;
    else if (shift_i) sr_d = lsb_i ? shr : shl;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

endmodule

// File: rtl/cva6_spi_master_tx_multi.sv
// SPI master transmit datapath for 1/2/4 SDO lanes with
// transfer-safe configuration latching and underrun reporting.
module cva6_spi_master_tx_multi
  import cva6_spi_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              tx_edge,
  input  logic [1:0]        mode_in,
  input  logic              lsb_first_in,
  input  logic [CNT_W-1:0]  counter_in,
  input  logic              counter_in_upd,
  input  logic [DATA_W-1:0] data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [3:0]        sdo,
  output logic [3:0]        sdo_oe,
  output logic              tx_done,
  output logic              underrun_o,
  output logic              clk_en_o
);

  tx_state_e        state_q;
  spi_mode_e        mode_q;
  spi_mode_e        pend_mode_q;
  spi_mode_e        new_mode;
  logic             lsb_q;
  logic             pend_lsb_q;
  logic             pend_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] trgt_q;
  logic [CNT_W-1:0] pend_trgt_q;
  logic [CNT_W-1:0] new_trgt;
  logic [CNT_W-1:0] wmask;
  logic             busy;
  logic             start;
  logic             last;
  logic             wb;
  logic             to_idle;

  assign new_mode = mode_dec(mode_in);

  always_comb begin
    new_trgt = counter_in >> lane_log2(new_mode);
    if (new_trgt == '0) new_trgt = CNT_W'(1);
  end

  always_comb begin
    case (mode_q)
      QUAD:    wmask = CNT_W'(DATA_W / 4 - 1);
      DUAL:    wmask = CNT_W'(DATA_W / 2 - 1);
      default: wmask = CNT_W'(DATA_W - 1);
    endcase
  end

  // rstn gates the start so no pop leaks out while reset is held.
  assign busy       = (state_q == TRANSMIT);
  assign start      = rstn & ~busy & en & data_valid;
  assign last       = busy & tx_edge & (cnt_q == trgt_q - CNT_W'(1));
  assign wb         = busy & tx_edge & ~last & ((cnt_q & wmask) == wmask);
  assign data_ready = start | (last & en & data_valid) | (wb & data_valid);
  assign tx_done    = last;
  assign underrun_o = wb & ~data_valid;
  assign clk_en_o   = busy & ~underrun_o;
  assign sdo_oe     = busy ? lane_mask(mode_q) : 4'b0000;
  assign to_idle    = (last & ~(en & data_valid)) | underrun_o;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      trgt_q      <= CNT_W'(TRGT_RST);
      mode_q      <= SINGLE;
      lsb_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_trgt_q <= '0;
      pend_mode_q <= SINGLE;
      pend_lsb_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE:     if (start)   state_q <= TRANSMIT;
        TRANSMIT: if (to_idle) state_q <= IDLE;
      endcase
      if (last)                 cnt_q <= '0;
      else if (busy && tx_edge) cnt_q <= cnt_q + CNT_W'(1);
      // Mid-transfer updates park in the pending slot until IDLE.
      if (counter_in_upd && busy && !to_idle) begin
        pend_q      <= 1'b1;
        pend_trgt_q <= new_trgt;
        pend_mode_q <= new_mode;
        pend_lsb_q  <= lsb_first_in;
      end else if (counter_in_upd) begin
        pend_q <= 1'b0;
        trgt_q <= new_trgt;
        mode_q <= new_mode;
        lsb_q  <= lsb_first_in;
      end else if (to_idle && pend_q) begin
        pend_q <= 1'b0;
        trgt_q <= pend_trgt_q;
        mode_q <= pend_mode_q;
        lsb_q  <= pend_lsb_q;
      end
    end
  end

  cva6_spi_tx_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk     (clk),
    .rstn    (rstn),
    .load_i  (data_ready),
    .clr_i   (to_idle),
    .shift_i (busy & tx_edge),
    .data_i  (data),
    .mode_i  (mode_q),
    .lsb_i   (lsb_q),
    .sdo_o   (sdo)
  );

endmodule

// File: tb/tb_cva6_spi_master_tx_multi.sv
// Self-checking bench for cva6_spi_master_tx_multi against a
// bit-stream reference model of the transmitted word sequence.
module tb_cva6_spi_master_tx_multi;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        tx_edge;
  logic [1:0]  mode_in;
  logic        lsb_first_in;
  logic [15:0] counter_in;
  logic        counter_in_upd;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [3:0]  sdo;
  logic [3:0]  sdo_oe;
  logic        tx_done;
  logic        underrun_o;
  logic        clk_en_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cva6_spi_master_tx_multi #(
    .DATA_W (32),
    .CNT_W  (16)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .en             (en),
    .tx_edge        (tx_edge),
    .mode_in        (mode_in),
    .lsb_first_in   (lsb_first_in),
    .counter_in     (counter_in),
    .counter_in_upd (counter_in_upd),
    .data           (data),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .sdo            (sdo),
    .sdo_oe         (sdo_oe),
    .tx_done        (tx_done),
    .underrun_o     (underrun_o),
    .clk_en_o       (clk_en_o)
  );

  logic [31:0] fifo[$];
  logic [31:0] wlog[$];
  bit m_active;
  bit m_lsb;
  bit m_pend;
  bit p_lsb;
  int m_k;
  int m_trgt;
  int m_L;
  int m_base;
  int p_trgt;
  int p_L;
  int obs_rdy;
  int obs_done;
  int obs_und;
  int obs_edges;

  function automatic int lanes_of(input logic [1:0] m);
    return (m == 2'b01) ? 2 : (m == 2'b10) ? 4 : 1;
  endfunction

  function automatic int trgt_of(input int cnt, input int lanes);
    int t;
    t = cnt / lanes;
    return (t == 0) ? 1 : t;
  endfunction

  // j-th group of L bits of a word in transmit order.
  function automatic logic [3:0] chunk(input logic [31:0] w, input int lanes,
                                       input bit lsb, input int j);
    int sh;
    logic [31:0] v;
    sh = lsb ? lanes * j : 32 - lanes * (j + 1);
    v = (w >> sh) & ((32'd1 << lanes) - 32'd1);
    return v[3:0];
  endfunction

  task automatic model_reset();
    m_active = 0; m_k = 0; m_trgt = 8; m_L = 1; m_lsb = 0;
    m_pend = 0; m_base = 0;
    wlog.delete();
  endtask

  task automatic clr_obs();
    obs_rdy = 0; obs_done = 0; obs_und = 0; obs_edges = 0;
  endtask

  task automatic pop_word();
    wlog.push_back(fifo.pop_front());
  endtask

  task automatic step(input bit e, input bit upd);
    logic [3:0] x_sdo;
    logic [3:0] x_oe;
    bit x_rdy, x_done, x_und, x_clk, was, v;
    int w;
    @(negedge clk);
    tx_edge = e;
    counter_in_upd = upd;
    v = (fifo.size() > 0);
    data_valid = v;
    data = v ? fifo[0] : $urandom;
    #1;
    w = 32 / m_L;
    was = m_active;
    x_sdo = m_active ? chunk(wlog[m_base + m_k / w], m_L, m_lsb, m_k % w) : 4'h0;
    x_oe = m_active ? 4'((1 << m_L) - 1) : 4'h0;
    x_rdy = 0; x_done = 0; x_und = 0; x_clk = m_active;
    if (!m_active) begin
      if (en && v) begin
        x_rdy = 1; pop_word(); m_active = 1;
        if (m_k == 0) m_base = wlog.size() - 1;
      end
    end else if (e) begin
      if (m_k == m_trgt - 1) begin
        x_done = 1; m_k = 0;
        if (en && v) begin
          x_rdy = 1; pop_word(); m_base = wlog.size() - 1;
        end else m_active = 0;
      end else begin
        m_k++;
        if (m_k % w == 0) begin
          if (v) begin x_rdy = 1; pop_word(); end
          else begin x_und = 1; x_clk = 0; m_active = 0; end
        end
      end
    end
    if (was && !m_active && m_pend) begin
      m_pend = 0; m_L = p_L; m_trgt = p_trgt; m_lsb = p_lsb;
    end
    if (upd) begin
      if (was && m_active) begin
        m_pend = 1; p_L = lanes_of(mode_in);
        p_trgt = trgt_of(int'(counter_in), p_L); p_lsb = lsb_first_in;
      end else begin
        m_pend = 0; m_L = lanes_of(mode_in);
        m_trgt = trgt_of(int'(counter_in), m_L); m_lsb = lsb_first_in;
      end
    end
    checks += 6;
    if (sdo !== x_sdo) begin errors++;
      $display("FAIL sdo t=%0t got %h exp %h", $time, sdo, x_sdo); end
    if (sdo_oe !== x_oe) begin errors++;
      $display("FAIL sdo_oe t=%0t got %b exp %b", $time, sdo_oe, x_oe); end
    if (data_ready !== x_rdy) begin errors++;
      $display("FAIL data_ready t=%0t got %b exp %b", $time, data_ready, x_rdy); end
    if (tx_done !== x_done) begin errors++;
      $display("FAIL tx_done t=%0t got %b exp %b", $time, tx_done, x_done); end
    if (underrun_o !== x_und) begin errors++;
      $display("FAIL underrun t=%0t got %b exp %b", $time, underrun_o, x_und); end
    if (clk_en_o !== x_clk) begin errors++;
      $display("FAIL clk_en t=%0t got %b exp %b", $time, clk_en_o, x_clk); end
    obs_rdy += int'(data_ready);
    obs_done += int'(tx_done);
    obs_und += int'(underrun_o);
    if (e && clk_en_o) obs_edges++;
  endtask

  task automatic set_cfg(input logic [1:0] m, input bit lsb, input int cnt);
    mode_in = m; lsb_first_in = lsb; counter_in = 16'(cnt);
    step(0, 1);
  endtask

  task automatic run_until_idle(input int max_cyc, input int gap, output int n);
    n = 0;
    step(0, 0);
    while ((m_active || (en && fifo.size() > 0)) && n < max_cyc) begin
      step(($urandom % gap) == 0, 0);
      n++;
    end
    if (m_active) begin
      checks++; errors++;
      $display("FAIL timeout after %0d cycles exp idle", n);
    end
  endtask

  task automatic test_reset();
    rstn = 0; en = 1; data_valid = 1; tx_edge = 1;
    data = 32'hFFFF_FFFF;
    #1;
    checks += 6;
    if (sdo !== 4'h0) begin errors++; $display("FAIL rst_sdo got %h exp 0", sdo); end
    if (sdo_oe !== 4'h0) begin errors++; $display("FAIL rst_oe got %b exp 0", sdo_oe); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", data_ready); end
    if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", tx_done); end
    if (underrun_o !== 1'b0) begin errors++; $display("FAIL rst_und got %b exp 0", underrun_o); end
    if (clk_en_o !== 1'b0) begin errors++; $display("FAIL rst_clken got %b exp 0", clk_en_o); end
    @(negedge clk);
    rstn = 1; en = 0; data_valid = 0; tx_edge = 0;
    model_reset();
  endtask

  task automatic test_default_trgt();
    int n;
    en = 1; clr_obs();
    fifo.push_back(32'hC000_0001);
    run_until_idle(100, 1, n);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL default_trgt edges got %0d exp 8", n); end
  endtask

  task automatic test_single_msb();
    int n;
    set_cfg(2'b00, 0, 32); clr_obs();
    fifo.push_back(32'hA500_0000);
    run_until_idle(300, 2, n);
    checks += 2;
    if (obs_done !== 1) begin errors++; $display("FAIL single_done got %0d exp 1", obs_done); end
    if (obs_rdy !== 1) begin errors++; $display("FAIL single_ready got %0d exp 1", obs_rdy); end
  endtask

  task automatic test_quad64();
    int n;
    set_cfg(2'b10, 0, 64); clr_obs();
    fifo.push_back(32'h1234_5678);
    fifo.push_back(32'h9ABC_DEF0);
    run_until_idle(100, 1, n);
    checks += 3;
    if (n !== 16) begin errors++; $display("FAIL quad_edges got %0d exp 16", n); end
    if (obs_rdy !== 2) begin errors++; $display("FAIL quad_ready got %0d exp 2", obs_rdy); end
    if (obs_done !== 1) begin errors++; $display("FAIL quad_done got %0d exp 1", obs_done); end
  endtask

  task automatic test_dual_lsb();
    int n;
    set_cfg(2'b01, 1, 8); clr_obs();
    fifo.push_back(32'h0000_00B4);
    run_until_idle(100, 1, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL dual_edges got %0d exp 4", n); end
  endtask

  task automatic test_underrun();
    int n;
    set_cfg(2'b00, 0, 64); clr_obs();
    fifo.push_back(32'hDEAD_BEEF);
    run_until_idle(200, 1, n);
    checks += 2;
    if (obs_und !== 1) begin errors++; $display("FAIL und_pulse got %0d exp 1", obs_und); end
    if (obs_done !== 0) begin errors++; $display("FAIL und_early_done got %0d exp 0", obs_done); end
    for (int i = 0; i < 3; i++) step(1, 0);
    fifo.push_back(32'h0F0F_1234);
    clr_obs();
    run_until_idle(200, 1, n);
    checks += 2;
    if (n !== 32) begin errors++; $display("FAIL und_resume_edges got %0d exp 32", n); end
    if (obs_done !== 1) begin errors++; $display("FAIL und_resume_done got %0d exp 1", obs_done); end
  endtask

  task automatic test_config_pending();
    int n;
    set_cfg(2'b00, 0, 32); clr_obs();
    fifo.push_back(32'h5A5A_C3C3);
    step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    mode_in = 2'b10; lsb_first_in = 0; counter_in = 16'd16;
    step(0, 1);
    run_until_idle(200, 1, n);
    checks++;
    if (n !== 27) begin errors++; $display("FAIL pend_cur_edges got %0d exp 27", n); end
    fifo.push_back(32'hFEDC_BA98);
    clr_obs();
    run_until_idle(100, 1, n);
    checks++;
    if (obs_edges !== 4) begin errors++; $display("FAIL pend_next_edges got %0d exp 4", obs_edges); end
  endtask

  task automatic test_reset_mid();
    set_cfg(2'b00, 0, 32);
    fifo.push_back(32'hFFFF_FFFF);
    step(0, 0);
    for (int i = 0; i < 9; i++) step(1, 0);
    @(negedge clk);
    tx_edge = 1; en = 1; data_valid = 1; rstn = 0;
    #1;
    checks += 6;
    if (sdo !== 4'h0) begin errors++; $display("FAIL midrst_sdo got %h exp 0", sdo); end
    if (sdo_oe !== 4'h0) begin errors++; $display("FAIL midrst_oe got %b exp 0", sdo_oe); end
    if (data_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", data_ready); end
    if (tx_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", tx_done); end
    if (underrun_o !== 1'b0) begin errors++; $display("FAIL midrst_und got %b exp 0", underrun_o); end
    if (clk_en_o !== 1'b0) begin errors++; $display("FAIL midrst_clken got %b exp 0", clk_en_o); end
    @(negedge clk);
    rstn = 1; en = 0; data_valid = 0; tx_edge = 0;
    fifo.delete();
    model_reset();
    en = 1;
  endtask

  task automatic test_back_to_back();
    int n;
    set_cfg(2'b00, 0, 8); clr_obs();
    fifo.push_back(32'hF000_0000);
    fifo.push_back(32'h8100_0000);
    fifo.push_back(32'h3C00_0000);
    run_until_idle(200, 1, n);
    checks += 3;
    if (n !== 24) begin errors++; $display("FAIL b2b_cycles got %0d exp 24", n); end
    if (obs_done !== 3) begin errors++; $display("FAIL b2b_done got %0d exp 3", obs_done); end
    if (obs_rdy !== 3) begin errors++; $display("FAIL b2b_ready got %0d exp 3", obs_rdy); end
  endtask

  task automatic test_random();
    int n, lanes, t, wpx, reps;
    logic [1:0] m;
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(0, 3));
      lanes = lanes_of(m);
      t = trgt_of($urandom_range(1, 100), 1);
      set_cfg(m, 1'($urandom_range(0, 1)), t);
      t = trgt_of(t, lanes);
      wpx = (t + 32 / lanes - 1) / (32 / lanes);
      reps = $urandom_range(1, 2);
      clr_obs();
      for (int i = 0; i < wpx * reps; i++) fifo.push_back($urandom);
      run_until_idle(2000, $urandom_range(1, 3), n);
      checks++;
      if (obs_done !== reps) begin errors++;
        $display("FAIL rand_done r=%0d got %0d exp %0d", r, obs_done, reps); end
    end
  endtask

  initial begin
    en = 0; tx_edge = 0; mode_in = 2'b00; lsb_first_in = 0;
    counter_in = '0; counter_in_upd = 0; data = '0; data_valid = 0;
    model_reset();
    clr_obs();
    test_reset();
    test_default_trgt();
    test_single_msb();
    test_quad64();
    test_dual_lsb();
    test_underrun();
    test_config_pending();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cva6_spi_master_tx_multi.md
# cva6_spi_master_tx_multi

Parametrised SPI master transmit datapath: serialises words from the controller's TX FIFO onto 1, 2 or 4 SDO lanes, MSB- or LSB-first, for a programmable bit count spanning any number of words. Sits between the TX FIFO and the SPI clock generator. It consumes `tx_edge` strobes and drives `clk_en_o` back. It adds dual mode, bit-order control, per-lane output enables, underrun reporting and transfer-safe configuration latching.

## Interface
- `DATA_W`, 32: FIFO word width. Must be a multiple of 4 and ≥ 8.
- `CNT_W`, 16: width of the bit-count field.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `en` in 1: transfer enable. Sampled only when starting a transfer.
- `tx_edge` in 1: one-cycle strobe from the clock generator, one per SCK shift edge.
- `mode_in` in 2: lane mode. 00 = single, 01 = dual, 10 = quad, 11 = single.
- `lsb_first_in` in 1: bit order. 1 = LSB first.
- `counter_in` in CNT_W: total bits to transmit.
- `counter_in_upd` in 1: strobe that loads `counter_in`, `mode_in` and `lsb_first_in`.
- `data` in DATA_W: FIFO head word.
- `data_valid` in 1: FIFO not empty.
- `data_ready` out 1: pop strobe. Combinational.
- `sdo` out 4: serial data lanes.
- `sdo_oe` out 4: per-lane output enable.
- `tx_done` out 1: last-edge pulse.
- `underrun_o` out 1: pulse when the FIFO is empty at a word boundary.
- `clk_en_o` out 1: SCK enable request.

## Operation
- **Lanes.** L = 1, 2 or 4 according to the latched mode.
- **Latched configuration.**
  - On `counter_in_upd`, the block computes `trgt = counter_in >> log2(L)`, using L from `mode_in`. If the result is 0, `trgt` = 1.
  - It latches `trgt`, the mode and the bit order.
  - If the strobe arrives while in TRANSMIT, the values are held in a pending register with a pending flag. They are applied in the cycle the FSM enters IDLE.
  - A second strobe before that point overwrites the pending values.
- **FSM states:** IDLE, TRANSMIT.
- **IDLE:**
  - `clk_en_o` = 0 and `sdo_oe` = 0.
  - If `en && data_valid`: load `data` into the shift register, assert `data_ready`, and go to TRANSMIT.
- **TRANSMIT:**
  - `clk_en_o` = 1.
  - `sdo_oe[L-1:0]` = 1; all other lanes are 0.
  - On each `tx_edge`: `counter`++ and the shift register shifts by L bits, zero-filled. MSB-first shifts left; LSB-first shifts right.
- **Lane mapping, MSB-first.** `sdo[L-1:0]` = top L bits of the shift register. `sdo[L-1]` carries the most significant of those bits.
- **Lane mapping, LSB-first.** `sdo[L-1:0]` = bottom L bits, with `sdo[0]` carrying the lowest.
- **Unused lanes.** Unused `sdo` lanes are driven 0.
- **Edges per word:** W = DATA_W/L.
- **Transfer end** (`tx_done`):
  - Condition: `tx_edge && counter == trgt-1 && state == TRANSMIT`.
  - `counter` is cleared to 0.
  - If `en && data_valid`: load the next word, pulse `data_ready`, and stay in TRANSMIT (back-to-back transfer).
  - Otherwise go to IDLE.
- **Word boundary** (`tx_edge && counter[log2(W)-1:0] == W-1`, when it is not the transfer end):
  - If `data_valid`: load the next word and pulse `data_ready`.
  - Otherwise pulse `underrun_o`, deassert `clk_en_o` in that cycle, and go to IDLE.
  - `counter` is retained. The next `en && data_valid` resumes the same transfer.
- **Transfer end wins.** When the transfer end and a word boundary coincide, the transfer-end rule applies.
- **Mid-word ends.** A `trgt` that is not a multiple of W ends mid-word. The remaining bits are discarded.

## Timing
- **Reset values:** state IDLE, `counter` 0, `trgt` 8, mode single, MSB-first, shift register 0, pending flag 0. Hence `sdo` = 0, `sdo_oe` = 0, `clk_en_o` = 0, `data_ready` = 0, `tx_done` = 0, `underrun_o` = 0.
- **Reset mid-transfer:** all state returns to the reset values immediately. No pop or done pulse is emitted.
- **Combinational outputs.** `data_ready`, `tx_done`, `underrun_o` and `clk_en_o` are combinational, asserted in the cycle of the qualifying `tx_edge` or start condition.
- **Registered outputs.** `sdo` is a function of registered state only. It changes one cycle after the edge.
- **Start latency.** The first bits are on `sdo` the cycle after `data_ready` in IDLE.
- **Gapless back-to-back transfers.** No idle cycle occurs between transfers when `data_valid` is high at `tx_done`.
- **Counter width.** `counter` is CNT_W bits. `trgt` ≤ 2^CNT_W − 1, so `counter` never wraps.

## Structure
- Shared package `cva6_spi_pkg` holds:
  - `spi_mode_e` (SINGLE, DUAL, QUAD), the mode decode function and the lane-count function.
  - `tx_state_e`.
  - The reset-target constant 8.
- Natural sub-module: `cva6_spi_tx_shreg`. It is the parametrised shift register with load, shift-by-L, bit-order selection and the lane-mapping output.

## Test plan
- **Single MSB-first.** DATA_W=32, `counter_in`=32, data 0xA5000000. Expected: `sdo[0]` sequence 1,0,1,0,0,1,0,1 then zeros; `tx_done` on edge 32; one `data_ready`; return to IDLE.
- **Quad, 64 bits.** Data 0x12345678 then 0x9ABCDEF0. Expected: nibbles 1..8 then 9..0 on `sdo[3:0]`; second `data_ready` on edge 8; `tx_done` on edge 16.
- **Dual LSB-first.** `counter_in`=8, data 0x000000B4. Expected: `sdo[1:0]` = 00,01,11,10; `sdo_oe`=0011; `tx_done` on edge 4.
- **Underrun.** Single mode, 64 bits, FIFO empty after word 1. Expected: `underrun_o` and `clk_en_o`=0 on edge 32. A refilled FIFO then resumes; `tx_done` occurs after 32 further edges.
- **Config during TRANSMIT.** `counter_in_upd` with quad/16 mid-transfer. Expected: the current transfer keeps single/32. The pending values apply on IDLE entry; the next transfer uses 4 edges.
- **Reset mid-transfer and back-to-back.** Assert `rstn` at edge 10: all outputs 0 within the same cycle. Separately: `data_valid` held high at `tx_done` gives the next word loaded in the same cycle, with no IDLE state.
